// File: rtl/memory_arbiter.sv
// memory_arbiter: serialises icache reads and dcache reads/writes onto one
// single-ported RAM, one registered transaction at a time.
//
// Ports:
//   CLK, RST           clock (rising edge), asynchronous active-high reset
//   iREN, iaddr        icache read request and word address
//   iwait, iload       icache wait (0 = read done this cycle), read data
//   dREN, dWEN         dcache read / write request (write wins if both)
//   daddr, dstore      dcache address and write data
//   dwait, dload       dcache wait (0 = access done this cycle), read data
//   ramREN, ramWEN     RAM read / write enables
//   ramaddr, ramstore  RAM address and write data
//   ramload, ramstate  RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   mem_err            one-cycle pulse after a transaction aborts on ERROR
module memory_arbiter #(
    parameter int WORD_W      = 32,
    parameter int DSTARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              mem_err
);

    localparam int SW = $clog2(DSTARVE_MAX + 1);
    localparam logic [SW-1:0] DMAX = SW'(DSTARVE_MAX);

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] dstreak_q, dstreak_d;
    logic          mem_err_q, mem_err_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            dstreak_q <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dstreak_q <= dstreak_d;
            mem_err_q <= mem_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dstreak_d = dstreak_q;
        mem_err_d = 1'b0;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        iwait     = 1'b1;
        dwait     = 1'b1;
        case (state_q)
            IDLE: begin
                // icache is forced once dcache has won DSTARVE_MAX times in a row
                if (iREN && dstreak_q == DMAX) begin
                    state_d = IACC;
                end else if (dREN || dWEN) begin
                    state_d = DACC;
                end else if (iREN) begin
                    state_d = IACC;
                end
            end
            IACC: begin
                ramaddr = iaddr;
                // a dropped request releases the RAM immediately, no completion
                if (!iREN) begin
                    state_d = IDLE;
                end else begin
                    ramREN = 1'b1;
                    if (ramstate == RS_ACCESS) begin
                        iwait     = 1'b0;
                        state_d   = IDLE;
                        dstreak_d = '0;
                    end else if (ramstate == RS_ERROR) begin
                        state_d   = IDLE;
                        mem_err_d = 1'b1;
                    end
                end
            end
            DACC: begin
                ramaddr  = daddr;
                ramstore = dstore;
                if (!(dREN || dWEN)) begin
                    state_d = IDLE;
                end else begin
                    ramWEN = dWEN;
                    ramREN = !dWEN;
                    if (ramstate == RS_ACCESS) begin
                        dwait   = 1'b0;
                        state_d = IDLE;
                        if (!iREN) begin
                            dstreak_d = '0;
                        end else if (dstreak_q != DMAX) begin
                            dstreak_d = dstreak_q + SW'(1);
                        end
                    end else if (ramstate == RS_ERROR) begin
                        state_d   = IDLE;
                        mem_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign iload   = ramload;
    assign dload   = ramload;
    assign mem_err = mem_err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of the arbiter.
module tb_memory_arbiter;

    localparam int W    = 32;
    localparam int DMAX = 4;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         iREN = 1'b0;
    logic [W-1:0] iaddr = '0;
    logic         iwait;
    logic [W-1:0] iload;
    logic         dREN = 1'b0;
    logic         dWEN = 1'b0;
    logic [W-1:0] daddr = '0;
    logic [W-1:0] dstore = '0;
    logic         dwait;
    logic [W-1:0] dload;
    logic         ramREN;
    logic         ramWEN;
    logic [W-1:0] ramaddr;
    logic [W-1:0] ramstore;
    logic [W-1:0] ramload = '0;
    logic [1:0]   ramstate = FREE;
    logic         mem_err;

    memory_arbiter #(.WORD_W(W), .DSTARVE_MAX(DMAX)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .mem_err(mem_err)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the RAM (0 none, 1 icache, 2 dcache),
    // how many dcache wins in a row while icache waited, pending error pulse.
    int owner;
    int streak;
    bit err_pulse;
    bit m_live;

    logic [132:0] exp_v;
    logic [132:0] act_v;
    assign act_v = {ramREN, ramWEN, ramaddr, ramstore, iwait, dwait,
                    iload, dload, mem_err};

    function automatic logic [132:0] model_out();
        logic         req;
        logic         ren, wen, iw, dw;
        logic [W-1:0] a, s;
        ren = 1'b0; wen = 1'b0; iw = 1'b1; dw = 1'b1;
        a = '0; s = '0;
        if (owner == 1) begin
            req = iREN;
            a   = iaddr;
            ren = req;
            iw  = !(req && ramstate == ACCESS);
        end else if (owner == 2) begin
            req = dREN || dWEN;
            a   = daddr;
            s   = dstore;
            wen = req && dWEN;
            ren = req && !dWEN;
            dw  = !(req && ramstate == ACCESS);
        end
        return {ren, wen, a, s, iw, dw, ramload, ramload, err_pulse};
    endfunction

    task automatic model_reset();
        owner     = 0;
        streak    = 0;
        err_pulse = 1'b0;
        m_live    = 1'b0;
    endtask

    task automatic model_adv();
        bit req, done, err;
        if (owner == 0) begin
            err_pulse = 1'b0;
            if (iREN && streak == DMAX) owner = 1;
            else if (dREN || dWEN)      owner = 2;
            else if (iREN)              owner = 1;
        end else begin
            req  = (owner == 1) ? iREN : (dREN || dWEN);
            done = req && ramstate == ACCESS;
            err  = req && ramstate == ERROR;
            err_pulse = err;
            if (done) begin
                if (owner == 2 && iREN) streak = (streak < DMAX) ? streak + 1 : DMAX;
                else                    streak = 0;
            end
            if (!req || done || err) owner = 0;
        end
    endtask

    // Advance the model over the edge just passed, then drive one cycle.
    task automatic apply(input logic ir, input logic [W-1:0] ia,
                         input logic dr, input logic dw,
                         input logic [W-1:0] da, input logic [W-1:0] ds,
                         input logic [1:0] rs, input logic [W-1:0] rl);
        if (m_live) model_adv();
        m_live = 1'b1;
        @(negedge CLK);
        iREN = ir; iaddr = ia; dREN = dr; dWEN = dw;
        daddr = da; dstore = ds; ramstate = rs; ramload = rl;
        #1;
        exp_v = model_out();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++)
            apply(1'b0, '0, 1'b0, 1'b0, '0, '0, FREE, '0);
    endtask

    task automatic test_reset();
        logic [67:0] got;
        model_reset();
        RST = 1'b1;
        iREN = 1'b1; dWEN = 1'b1; daddr = 32'h10; dstore = 32'h99;
        ramstate = ACCESS;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK); #1;
            got = {ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, mem_err};
            n_checks++;
            if (got !== {1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_outputs: got %h want idle outputs", got);
            end
        end
        @(negedge CLK);
        iREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0; ramstate = FREE;
        RST = 1'b0;
        m_live = 1'b1;
    endtask

    task automatic test_lone_iread();
        apply(1'b1, 32'h40, 1'b0, 1'b0, '0, '0, FREE, '0);
        n_checks++;
        if (ramREN !== 1'b0) begin
            n_fail++; $display("FAIL iread_c0: ramREN %b want 0", ramREN);
        end
        for (int c = 1; c <= 2; c++) begin
            apply(1'b1, 32'h40, 1'b0, 1'b0, '0, '0, BUSY, '0);
            n_checks++;
            if ({ramREN, ramaddr, iwait} !== {1'b1, 32'h40, 1'b1}) begin
                n_fail++;
                $display("FAIL iread_busy c%0d: ren %b addr %h iwait %b want 1 40 1",
                         c, ramREN, ramaddr, iwait);
            end
        end
        apply(1'b1, 32'h40, 1'b0, 1'b0, '0, '0, ACCESS, 32'hDEADBEEF);
        n_checks++;
        if ({iwait, iload, dwait} !== {1'b0, 32'hDEADBEEF, 1'b1}) begin
            n_fail++;
            $display("FAIL iread_done: iwait %b iload %h dwait %b want 0 deadbeef 1",
                     iwait, iload, dwait);
        end
        apply(1'b0, '0, 1'b0, 1'b0, '0, '0, FREE, '0);
        n_checks++;
        if ({ramREN, iwait} !== {1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL iread_idle: ren %b iwait %b want 0 1", ramREN, iwait);
        end
    endtask

    task automatic test_simultaneous();
        apply(1'b1, 32'h44, 1'b0, 1'b1, 32'h80, 32'h1234, ACCESS, '0);
        apply(1'b1, 32'h44, 1'b0, 1'b1, 32'h80, 32'h1234, ACCESS, '0);
        n_checks++;
        if ({ramWEN, ramREN, ramaddr, ramstore, dwait, iwait} !==
            {1'b1, 1'b0, 32'h80, 32'h1234, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL simul_dwrite: wen %b ren %b addr %h st %h dw %b iw %b",
                     ramWEN, ramREN, ramaddr, ramstore, dwait, iwait);
        end
        apply(1'b1, 32'h44, 1'b0, 1'b0, '0, '0, ACCESS, '0);
        n_checks++;
        if ({ramREN, ramWEN, iwait} !== {1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL simul_bubble: ren %b wen %b iw %b want 0 0 1",
                     ramREN, ramWEN, iwait);
        end
        apply(1'b1, 32'h44, 1'b0, 1'b0, '0, '0, ACCESS, 32'h5);
        n_checks++;
        if ({ramREN, ramaddr, iwait, dwait} !== {1'b1, 32'h44, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL simul_iread: ren %b addr %h iw %b dw %b want 1 44 0 1",
                     ramREN, ramaddr, iwait, dwait);
        end
        idle_cycles(1);
    endtask

    task automatic test_starvation();
        int got, want;
        for (int k = 0; k < 22; k++) begin
            apply(1'b1, 32'h44, 1'b1, 1'b0, 32'h88, '0, ACCESS, k);
            got  = !dwait ? 2 : (!iwait ? 1 : 0);
            want = (k % 2 == 0) ? 0 : ((k == 9 || k == 19) ? 1 : 2);
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL starve cycle %0d: completer %0d want %0d", k, got, want);
            end
        end
        idle_cycles(1);
    endtask

    task automatic test_both_rw();
        apply(1'b0, '0, 1'b1, 1'b1, 32'hA0, 32'h55, ACCESS, '0);
        apply(1'b0, '0, 1'b1, 1'b1, 32'hA0, 32'h55, ACCESS, '0);
        n_checks++;
        if ({ramWEN, ramREN, ramaddr, ramstore, dwait} !==
            {1'b1, 1'b0, 32'hA0, 32'h55, 1'b0}) begin
            n_fail++;
            $display("FAIL both_rw: wen %b ren %b addr %h st %h dw %b want 1 0 a0 55 0",
                     ramWEN, ramREN, ramaddr, ramstore, dwait);
        end
        idle_cycles(1);
    endtask

    task automatic test_error();
        apply(1'b0, '0, 1'b1, 1'b0, 32'hC0, '0, FREE, '0);
        apply(1'b0, '0, 1'b1, 1'b0, 32'hC0, '0, ERROR, '0);
        n_checks++;
        if ({ramREN, dwait, mem_err} !== {1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL err_abort: ren %b dw %b err %b want 1 1 0",
                     ramREN, dwait, mem_err);
        end
        apply(1'b0, '0, 1'b1, 1'b0, 32'hC0, '0, FREE, '0);
        n_checks++;
        if ({ramREN, dwait, mem_err} !== {1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL err_pulse: ren %b dw %b err %b want 0 1 1",
                     ramREN, dwait, mem_err);
        end
        apply(1'b0, '0, 1'b1, 1'b0, 32'hC0, '0, ACCESS, 32'h77);
        n_checks++;
        if ({ramREN, dwait, mem_err, dload} !== {1'b1, 1'b0, 1'b0, 32'h77}) begin
            n_fail++;
            $display("FAIL err_retry: ren %b dw %b err %b dload %h want 1 0 0 77",
                     ramREN, dwait, mem_err, dload);
        end
        idle_cycles(1);
    endtask

    task automatic test_reset_mid();
        apply(1'b1, 32'h50, 1'b0, 1'b0, '0, '0, BUSY, '0);
        apply(1'b1, 32'h50, 1'b0, 1'b0, '0, '0, BUSY, '0);
        n_checks++;
        if (ramREN !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_grant: ren %b want 1", ramREN);
        end
        RST = 1'b1;
        #1;
        n_checks++;
        if ({ramREN, iwait} !== {1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL rstmid_async: ren %b iw %b want 0 1", ramREN, iwait);
        end
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        m_live = 1'b1;
        #1;
        n_checks++;
        if (ramREN !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_idle: ren %b want 0", ramREN);
        end
        apply(1'b1, 32'h50, 1'b0, 1'b0, '0, '0, BUSY, '0);
        n_checks++;
        if ({ramREN, ramaddr} !== {1'b1, 32'h50}) begin
            n_fail++;
            $display("FAIL rstmid_regrant: ren %b addr %h want 1 50", ramREN, ramaddr);
        end
        apply(1'b1, 32'h50, 1'b0, 1'b0, '0, '0, ACCESS, 32'h3);
        n_checks++;
        if (iwait !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_done: iw %b want 0", iwait);
        end
        idle_cycles(1);
    endtask

    task automatic test_random();
        logic ir, dr, dw;
        ir = 1'b0; dr = 1'b0; dw = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 3) == 0) ir = 1'($urandom);
            if ($urandom_range(0, 3) == 0) dr = 1'($urandom);
            if ($urandom_range(0, 3) == 0) dw = ($urandom_range(0, 2) == 0);
            apply(ir, $urandom, dr, dw, $urandom, $urandom,
                  2'($urandom_range(0, 3)), $urandom);
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %h want %h", k, act_v, exp_v);
            end
        end
        idle_cycles(1);
    endtask

    initial begin
        test_reset();
        test_lone_iread();
        test_simultaneous();
        test_starvation();
        test_both_rw();
        test_error();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
